// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
//   Shared types and default constants for the synchronous front-end of the
//   asynchronous 8-bit SRAM macro.
//
//   Contents:
//     state_t       controller state encoding
//     *_DEF         default address/data widths and timing (in clk cycles)
//     max3()        elaboration-time helper used to size the wait counter
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 8;
  localparam int WR_SETUP_DEF = 1;
  localparam int WR_PULSE_DEF = 2;
  localparam int RD_WAIT_DEF  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_RD_ACCESS
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
//   Synchronous front-end for an asynchronous SRAM macro. Accepts single-beat
//   valid/ready read and write requests and turns them into Cs_b/We_b/Oe_b
//   strobe sequences with programmable wait states. Owns the bidirectional
//   data bus: drives it only for the duration of a write and samples it on the
//   final edge of a read access.
//
//   Parameters:
//     ADDR_W    SRAM address width
//     DATA_W    SRAM data width
//     WR_SETUP  cycles of address/data/Cs_b setup before We_b falls (>=1)
//     WR_PULSE  cycles We_b is held low (>=1)
//     RD_WAIT   cycles of Cs_b/Oe_b low before read data is sampled (>=1)
//
//   Ports:
//     clk        clock, rising edge
//     rst_b      asynchronous active-low reset
//     req_valid  request present
//     req_ready  controller idle; accept on req_valid && req_ready
//     req_we     1 = write, 0 = read
//     req_addr   request address
//     req_wdata  write data
//     rsp_valid  one-cycle completion pulse (reads and writes)
//     rsp_rdata  read data, held until the next read completes
//     Cs_b       SRAM chip select, active low
//     We_b       SRAM write enable, active low (SRAM commits on rising edge)
//     Oe_b       SRAM output enable, active low
//     Address    SRAM address
//     IO         SRAM bidirectional data bus
// -----------------------------------------------------------------------------
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WR_SETUP = WR_SETUP_DEF,
  parameter int WR_PULSE = WR_PULSE_DEF,
  parameter int RD_WAIT  = RD_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              Cs_b,
  output logic              We_b,
  output logic              Oe_b,
  output logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] IO
);

  // Wait counter is wide enough for the longest programmable phase; each
  // phase loads (N-1) and advances when the count reaches zero, so a phase
  // of N cycles spans exactly N clock edges.
  localparam int CNT_W = $clog2(max3(WR_SETUP, WR_PULSE, RD_WAIT) + 1);

  localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(WR_SETUP - 1);
  localparam logic [CNT_W-1:0] C_PULSE = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] C_RD    = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cs_b;
  logic              r_we_b;
  logic              r_oe_b;
  logic              r_io_oe;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_accept;
  logic              w_cnt_done;

  assign w_accept   = req_valid && r_req_ready;
  assign w_cnt_done = (r_cnt == '0);

  // Every SRAM-facing signal, including the bus driver enable, is a flop
  // output so the asynchronous macro never sees decode glitches.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cs_b      <= 1'b1;
      r_we_b      <= 1'b1;
      r_oe_b      <= 1'b1;
      r_io_oe     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order in this block.
      r_rsp_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr      <= req_addr;
            r_req_ready <= 1'b0;
            r_cs_b      <= 1'b0;
            if (req_we) begin
              r_wdata <= req_wdata;
              r_io_oe <= 1'b1;
              r_cnt   <= C_SETUP;
              r_state <= ST_WR_SETUP;
            end else begin
              r_oe_b  <= 1'b0;
              r_cnt   <= C_RD;
              r_state <= ST_RD_ACCESS;
            end
          end
        end

        ST_WR_SETUP: begin
          if (w_cnt_done) begin
            r_we_b  <= 1'b0;
            r_cnt   <= C_PULSE;
            r_state <= ST_WR_PULSE;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end

        ST_WR_PULSE: begin
          if (w_cnt_done) begin
            // Rising We_b commits the word; Cs_b, Address and IO stay put
            // for one more cycle to give the macro data hold time.
            r_we_b  <= 1'b1;
            r_state <= ST_WR_HOLD;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end

        ST_WR_HOLD: begin
          r_cs_b      <= 1'b1;
          r_io_oe     <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end

        ST_RD_ACCESS: begin
          if (w_cnt_done) begin
            // IO is sampled on the same edge that deasserts Oe_b, so the
            // macro is still driving valid data at this instant.
            r_rsp_rdata <= IO;
            r_rsp_valid <= 1'b1;
            r_cs_b      <= 1'b1;
            r_oe_b      <= 1'b1;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end

        default: begin
          r_cs_b      <= 1'b1;
          r_we_b      <= 1'b1;
          r_oe_b      <= 1'b1;
          r_io_oe     <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign IO        = r_io_oe ? r_wdata : {DATA_W{1'bz}};
  assign Cs_b      = r_cs_b;
  assign We_b      = r_we_b;
  assign Oe_b      = r_oe_b;
  assign Address   = r_addr;
  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
//   Two controller instances: index 0 with default timing, index 1 with
//   WR_SETUP=3, WR_PULSE=1, RD_WAIT=4. Each drives its own behavioural
//   asynchronous SRAM on a pulled-up bus (released bus reads 8'hFF).
// -----------------------------------------------------------------------------
module tb_sram_ctrl;

  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
    bit         chk;
  } req_t;

  logic            clk = 1'b0;
  logic            rst_b = 1'b1;
  logic [1:0]      req_valid;
  logic [1:0]      req_we;
  logic [7:0]      req_addr  [2];
  logic [7:0]      req_wdata [2];
  wire  [1:0]      req_ready;
  wire  [1:0]      rsp_valid;
  wire  [1:0][7:0] rsp_rdata;
  wire  [1:0]      cs_b;
  wire  [1:0]      we_b;
  wire  [1:0]      oe_b;
  wire  [1:0][7:0] addr;
  wire  [7:0]      io0;
  wire  [7:0]      io1;

  int n_checks = 0;
  int n_errors = 0;

  req_t       q[$];
  logic [7:0] model  [2][256];
  bit         mvalid [2][256];
  logic [7:0] last_rdata [2];
  logic [7:0] sram0 [256];
  logic [7:0] sram1 [256];

  always #5 clk = ~clk;

  sram_ctrl u_dut0 (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .Cs_b(cs_b[0]), .We_b(we_b[0]), .Oe_b(oe_b[0]),
    .Address(addr[0]), .IO(io0)
  );

  sram_ctrl #(.WR_SETUP(3), .WR_PULSE(1), .RD_WAIT(4)) u_dut1 (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .Cs_b(cs_b[1]), .We_b(we_b[1]), .Oe_b(oe_b[1]),
    .Address(addr[1]), .IO(io1)
  );

  // Behavioural asynchronous SRAMs: drive only when selected and output
  // enabled with We_b high; commit on the rising edge of We_b.
  pullup (io0);
  pullup (io1);
  assign io0 = (cs_b[0] == 1'b0 && oe_b[0] == 1'b0 && we_b[0] == 1'b1) ? sram0[addr[0]] : 8'bz;
  assign io1 = (cs_b[1] == 1'b0 && oe_b[1] == 1'b0 && we_b[1] == 1'b1) ? sram1[addr[1]] : 8'bz;
  always @(posedge we_b[0]) if (cs_b[0] == 1'b0) sram0[addr[0]] = io0;
  always @(posedge we_b[1]) if (cs_b[1] == 1'b0) sram1[addr[1]] = io1;

  function automatic int t_setup(input int i); return (i == 1) ? 3 : 1; endfunction
  function automatic int t_pulse(input int i); return (i == 1) ? 1 : 2; endfunction
  function automatic int t_rd(input int i);    return (i == 1) ? 4 : 2; endfunction

  function automatic logic [7:0] io_of(input int i);
    return (i == 1) ? io1 : io0;
  endfunction

  function automatic logic [7:0] dev_of(input int i, input logic [7:0] a);
    return (i == 1) ? sram1[a] : sram0[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain array of last-written values per instance.
  task automatic push_req(input int i, input bit we, input logic [7:0] a, input logic [7:0] d);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d; r.exp = 8'h00; r.chk = 1'b0;
    if (we) begin
      model[i][a]  = d;
      mvalid[i][a] = 1'b1;
    end else begin
      r.exp = model[i][a];
      r.chk = mvalid[i][a];
    end
    q.push_back(r);
  endtask

  task automatic push_tbl(input int i, input req_t r);
    if (r.we) begin
      model[i][r.addr]  = r.wdata;
      mvalid[i][r.addr] = 1'b1;
    end
    q.push_back(r);
  endtask

  // Drains q through instance i. With gaps=0 req_valid stays high while
  // requests remain (stalled requester); with gaps=1 idle cycles are random.
  task automatic run_stream(input int i, input bit gaps);
    int   total, done, budget, cyc, ncs, nwe, noe, lat;
    bit   flight, will, presenting;
    req_t cur;
    total = q.size(); done = 0; budget = total * 30 + 50;
    flight = 0; will = 0; presenting = 0;
    cyc = 0; ncs = 0; nwe = 0; noe = 0;
    cur = '{0, 8'h00, 8'h00, 8'h00, 0};
    while (done < total) begin
      @(negedge clk);
      if (budget == 0) begin
        check("stream_timeout", done, total);
        break;
      end
      budget--;
      if (will) begin
        flight = 1; will = 0;
        cur = q.pop_front();
        cyc = 0; ncs = 0; nwe = 0; noe = 0;
      end
      if (flight) begin
        cyc++;
        if (cs_b[i] == 1'b0) begin
          ncs++;
          check("addr_stable", addr[i], cur.addr);
          if (cur.we) begin
            check("wr_bus", io_of(i), cur.wdata);
            check("wr_oe_high", oe_b[i], 1);
          end else begin
            check("rd_bus", io_of(i), dev_of(i, cur.addr));
          end
        end
        if (we_b[i] == 1'b0) nwe++;
        if (oe_b[i] == 1'b0) noe++;
      end
      if (cs_b[i] == 1'b1) check("bus_released", io_of(i), 8'hFF);
      if (rsp_valid[i]) begin
        if (!flight) begin
          check("spurious_rsp", 1, 0);
        end else begin
          lat = cur.we ? t_setup(i) + t_pulse(i) + 2 : t_rd(i) + 1;
          check("rsp_latency", cyc, lat);
          if (cur.we) begin
            check("wr_cs_width", ncs, t_setup(i) + t_pulse(i) + 1);
            check("wr_we_width", nwe, t_pulse(i));
            check("wr_oe_width", noe, 0);
            check("rdata_hold", rsp_rdata[i], last_rdata[i]);
          end else begin
            check("rd_cs_width", ncs, t_rd(i));
            check("rd_oe_width", noe, t_rd(i));
            check("rd_we_width", nwe, 0);
            if (cur.chk) check("rd_data", rsp_rdata[i], cur.exp);
            last_rdata[i] = rsp_rdata[i];
          end
          done++;
          flight = 0;
        end
      end else begin
        check("rdata_hold", rsp_rdata[i], last_rdata[i]);
      end
      check("ready_idle", req_ready[i], !flight);
      // Drive: keep a presented request stable until it is accepted.
      if (!presenting && q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
        presenting   = 1;
        req_valid[i] = 1'b1;
        req_we[i]    = q[0].we;
        req_addr[i]  = q[0].addr;
        req_wdata[i] = q[0].wdata;
      end else if (!presenting) begin
        req_valid[i] = 1'b0;
      end
      if (presenting && req_ready[i]) begin
        will = 1;
        presenting = 0;
      end
    end
    @(negedge clk);
    req_valid[i] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_cs_b"},  cs_b[i], 1);
      check({tag, "_we_b"},  we_b[i], 1);
      check({tag, "_oe_b"},  oe_b[i], 1);
      check({tag, "_addr"},  addr[i], 0);
      check({tag, "_io"},    io_of(i), 8'hFF);
      check({tag, "_ready"}, req_ready[i], 1);
      check({tag, "_rsp"},   rsp_valid[i], 0);
      check({tag, "_rdata"}, rsp_rdata[i], 0);
    end
  endtask

  initial begin
    req_t tbl [8];
    bit   hit;

    tbl[0] = '{1, 8'h3C, 8'hA5, 8'h00, 0};
    tbl[1] = '{0, 8'h3C, 8'h00, 8'hA5, 1};
    tbl[2] = '{1, 8'h00, 8'h11, 8'h00, 0};
    tbl[3] = '{1, 8'hFF, 8'h22, 8'h00, 0};
    tbl[4] = '{0, 8'h00, 8'h00, 8'h11, 1};
    tbl[5] = '{0, 8'hFF, 8'h00, 8'h22, 1};
    tbl[6] = '{1, 8'h7E, 8'h7E, 8'h00, 0};
    tbl[7] = '{0, 8'h7E, 8'h00, 8'h7E, 1};

    req_valid = '0;
    req_we    = '0;
    for (int i = 0; i < 2; i++) begin
      req_addr[i]   = 8'h00;
      req_wdata[i]  = 8'h00;
      last_rdata[i] = 8'h00;
    end

    // Reset: hold, release, then check idle outputs.
    #2 rst_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_b = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    for (int a = 0; a < 256; a++) begin
      sram0[a] = 8'h00; sram1[a] = 8'h00;
      model[0][a] = 8'h00; model[1][a] = 8'h00;
      mvalid[0][a] = 1'b1; mvalid[1][a] = 1'b1;
    end

    // Write 0xA5 to 0x3C then read it back.
    for (int k = 0; k < 2; k++) push_tbl(0, tbl[k]);
    run_stream(0, 0);

    // Back-to-back with req_valid held continuously (stalls while busy).
    for (int k = 2; k < 6; k++) push_tbl(0, tbl[k]);
    run_stream(0, 0);

    // Reset in WR_PULSE: pre-write 0x5A to 0x40, abort a write to 0x41.
    push_req(0, 1, 8'h40, 8'h5A);
    run_stream(0, 0);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h41; req_wdata[0] = 8'h99;
    check("abort_accept_ready", req_ready[0], 1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    hit = 0;
    for (int c = 0; c < 10 && !hit; c++) begin
      if (we_b[0] == 1'b0) hit = 1;
      else @(negedge clk);
    end
    check("reached_wr_pulse", hit, 1);
    #2 rst_b = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    last_rdata[0] = 8'h00;
    last_rdata[1] = 8'h00;
    mvalid[0][8'h41] = 1'b0;
    mvalid[0][8'h00] = 1'b0;
    hit = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid[0]) hit = 1;
    end
    check("abort_no_rsp", hit, 0);
    push_req(0, 0, 8'h40, 8'h00);
    check("abort_reread_exp", q[0].exp, 8'h5A);
    run_stream(0, 0);

    // Randomized traffic on a small address window against the model.
    for (int k = 0; k < 40; k++)
      push_req(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
    run_stream(0, 1);

    // Timing variant instance.
    for (int k = 6; k < 8; k++) push_tbl(1, tbl[k]);
    run_stream(1, 0);
    for (int k = 0; k < 40; k++)
      push_req(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
    run_stream(1, 0);
    for (int k = 0; k < 30; k++)
      push_req(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
    run_stream(1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
